// File: rtl/parity_pkg.sv
// Shared types and constants for the parity generator and the framed serial transmitter.
package parity_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned FRAME_BITS = DEF_DATA_W + 3;

  localparam bit PARITY_EVEN_SEL = 1'b0;
  localparam bit PARITY_ODD_SEL  = 1'b1;

  // Clocks occupied by one frame of a given word width and bit time.
  function automatic int unsigned frame_clks(input int unsigned data_w, input int unsigned cpb);
    return (data_w + 3) * cpb;
  endfunction

endpackage

// File: rtl/parity_frame_tx_if.sv
// Producer-side valid/ready handshake carrying one data word into the frame transmitter.
interface parity_frame_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;

  modport master (output data_in, output valid_in, input  ready_out);
  modport slave  (input  data_in, input  valid_in, output ready_out);
endinterface

// File: rtl/parity_gen.sv
// Combinational parity of a data word; PARITY_ODD inverts the even-parity result.
module parity_gen
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter bit          PARITY_ODD = PARITY_EVEN_SEL
) (
  input  logic [DATA_W-1:0] data,
  output logic              parity_c
);

  assign parity_c = (^data) ^ PARITY_ODD;

endmodule

// File: rtl/parity_frame_tx.sv
// Serialises one accepted word per frame: start, data LSB first, parity, stop; each bit held CLKS_PER_BIT clocks.
module parity_frame_tx
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_ODD   = PARITY_EVEN_SEL
) (
  input  logic                clk,
  input  logic                rst_n,
  parity_frame_tx_if.slave    link,
  output logic                tx_out,
  output logic                busy,
  output logic                parity_bit
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned IDX_W = $clog2(DATA_W) + 1;

  frame_state_t      state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [IDX_W-1:0]  idx_q, idx_n;
  logic [DATA_W-1:0] sh_q, sh_n;
  logic              par_q, par_n;
  logic              tx_q, tx_n;
  logic              ready_q, ready_n;
  logic              busy_q;
  logic              par_c;
  logic              bit_end;
  logic              last_bit;

  parity_gen #(
    .DATA_W     (DATA_W),
    .PARITY_ODD (PARITY_ODD)
  ) u_parity_gen (
    .data     (link.data_in),
    .parity_c (par_c)
  );

  assign bit_end  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign last_bit = (idx_q == IDX_W'(DATA_W - 1));

  // Next-state and next-output computation; tx/ready are registered from these.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q + CNT_W'(1);
    idx_n   = idx_q;
    sh_n    = sh_q;
    par_n   = par_q;
    tx_n    = tx_q;
    ready_n = ready_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_n   = '0;
        tx_n    = 1'b1;
        ready_n = 1'b1;
        if (link.valid_in && ready_q) begin
          sh_n    = link.data_in;
          par_n   = par_c;
          state_n = ST_START;
          tx_n    = 1'b0;
          ready_n = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_n = ST_DATA;
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = sh_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (last_bit) begin
            state_n = ST_PARITY;
            tx_n    = par_q;
          end else begin
            sh_n  = sh_q >> 1;
            idx_n = idx_q + IDX_W'(1);
            tx_n  = sh_n[0];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_n = ST_STOP;
          cnt_n   = '0;
          tx_n    = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          tx_n    = 1'b1;
          ready_n = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        idx_n   = '0;
        tx_n    = 1'b1;
        ready_n = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      sh_q    <= sh_n;
      par_q   <= par_n;
      tx_q    <= tx_n;
      ready_q <= ready_n;
      busy_q  <= ~ready_n;
    end
  end

  assign link.ready_out = ready_q;
  assign tx_out         = tx_q;
  assign busy           = busy_q;
  assign parity_bit     = par_q;

endmodule

// File: doc/parity_frame_tx.md
# parity_frame_tx

Sequencing controller wrapped around the even-parity generator. It accepts one data word per valid/ready handshake and serialises it onto a single line as a frame: start bit, data LSB first, parity bit, stop bit. Each bit is held for a programmable number of clocks. It sits between a byte producer and the serial link, and is the first clocked consumer of the parity function.

## Interface
- `DATA_W`, default 8: data word width, legal range 1..16.
- `CLKS_PER_BIT`, default 4: clocks each frame bit is held, legal range ≥1.
- `PARITY_ODD`, default 0: 0 selects even parity (the parity bit makes the total count of ones even); 1 selects odd parity.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `data_in` in DATA_W: word to transmit; sampled only on the accept cycle.
- `valid_in` in 1: producer has a word.
- `ready_out` out 1: controller can accept; high only in IDLE.
- `tx_out` out 1: serial line, registered; idle level 1.
- `busy` out 1: high whenever a frame is in progress (`~ready_out`).
- `parity_bit` out 1: parity of the last accepted word, registered, held until the next accept.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx_out`=1, `ready_out`=1.
  - Accept occurs when `valid_in && ready_out`.
  - On accept: latch `data_in` into the shift register, latch `parity_bit` = (^`data_in`) ^ `PARITY_ODD`, go to START.
- START: `tx_out`=0 for CLKS_PER_BIT clocks, then go to DATA with bit index 0.
- DATA: `tx_out` = shift register bit 0. Each bit lasts CLKS_PER_BIT clocks, then the register shifts right and the index increments. After index DATA_W-1 completes, go to PARITY.
- PARITY: `tx_out` = `parity_bit` for CLKS_PER_BIT clocks, then go to STOP.
- STOP: `tx_out`=1 for CLKS_PER_BIT clocks, then go to IDLE.
- Bit-time counter:
  - width clog2(CLKS_PER_BIT)+1;
  - cleared on every state or bit change;
  - a bit ends when the counter reaches CLKS_PER_BIT-1.
- Bit index counter: width clog2(DATA_W)+1, no wrap beyond DATA_W-1.
- `valid_in` while busy: ignored, with no queuing and no side effects. Changes on `data_in` after accept do not affect the frame in flight.
- Reset values: state IDLE, `tx_out`=1, `ready_out`=1, `busy`=0, `parity_bit`=0, shift register 0, both counters 0.
- Asserting `rst_n` mid-frame aborts the frame immediately (asynchronously): `tx_out` returns to 1 and the word is discarded. After release, the first accept may occur on the first clock edge.

## Timing
- Accept at rising edge E0: `tx_out`=0 and `ready_out`=0 are visible right after E0.
- Start bit occupies edges E0..E(CPB).
- Data bit i appears after edge E((i+1)·CPB).
- Parity bit appears after edge E((DATA_W+1)·CPB).
- Stop bit appears after edge E((DATA_W+2)·CPB).
- `ready_out` returns to 1 after edge E((DATA_W+3)·CPB).
- Frame length is (DATA_W+3)·CLKS_PER_BIT clocks. With defaults that is 44.
- Back-to-back: if `valid_in` is high the whole time, the next accept occurs at the first edge after `ready_out` rises. The minimum line-high interval between frames is therefore CPB+1 clocks: stop bit plus one IDLE cycle.
- CLKS_PER_BIT=1 must work; each bit then lasts exactly one clock.

## Structure
- Shared package `parity_pkg` holds:
  - the state enum `frame_state_t`;
  - the localparam `FRAME_BITS = DATA_W+3`;
  - the parity polarity constants.
- One sub-module: `parity_gen`, purely combinational, parameterised DATA_W and PARITY_ODD. It computes the parity bit for the accept cycle and is the same function used by the existing even-parity block.
- Top module holds the FSM, the two counters, the shift register and the output registers.

## Test plan
1. Reset then idle: hold `rst_n`=0, then release with `valid_in`=0 for 20 clocks. Required: `tx_out`=1, `ready_out`=1, `busy`=0, `parity_bit`=0 throughout.
2. Single frame, CPB=4: `data_in`=8'b10101010. Required:
   - `parity_bit`=0;
   - `tx_out` sampled mid-bit reads 0, 0,1,0,1,0,1,0,1, 0, 1;
   - `ready_out` high again 44 clocks after accept.
3. Odd count of ones: 8'b10000000 gives `parity_bit`=1, and the parity slot on `tx_out` is 1. 8'b11110000 gives `parity_bit`=0.
4. Back-to-back: `valid_in` held high with 8'h0F then 8'hF1.
   - Two frames appear with exactly CPB+1 line-high clocks between them.
   - The second frame's parity is 1.
   - 8'hF1 is not accepted before `ready_out`=1.
5. Busy-time stimulus: toggle `data_in` and `valid_in` during DATA. Required: transmitted bits and parity match the word latched at accept, and no extra frame is sent.
6. Reset mid-frame: assert `rst_n`=0 during DATA bit 3. Required:
   - `tx_out`=1 and `ready_out`=1 immediately;
   - after release, a new accept of 8'h55 produces a clean, full 44-clock frame with `parity_bit`=0.
